// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM encoding and
// output buffer sizing.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH          = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 8;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry registered valid/ready buffer. Push and pop may coincide at any
// occupancy, including full; the head is always a register, never a bypass.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [data_width-1:0] data_o,
  output logic                  valid_o,
  output logic [1:0]            count_o,
  output logic [1:0]            count_d_o
);

  logic [data_width-1:0] mem_q [BUF_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // When full, a push is only taken if the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'(BUF_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign data_o    = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != 2'd0);
  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side burst controller: pulls words from the async FIFO read port with
// credit-based flow control and hands them to a valid/ready stream.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int cnt_width  = DEFAULT_CNT_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [cnt_width-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [data_width-1:0] fifo_rdata,
  input  logic                  fifo_valid,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [cnt_width-1:0]  words_read,
  output logic                  err
);

  state_e               state_q;
  logic [cnt_width-1:0] issue_left_q;
  logic [cnt_width-1:0] recv_left_q;
  logic [cnt_width-1:0] words_read_q;
  logic                 in_flight_q;
  logic                 in_flight_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic                 push;
  logic                 pop;
  logic [1:0]           buf_count;
  logic [1:0]           buf_count_d;
  logic [2:0]           credit;

  fifo_skid_buf #(.data_width(data_width)) u_buf (
    .clk_i       (rd_clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (fifo_rdata),
    .pop_i       (pop),
    .data_o      (m_data),
    .valid_o     (m_valid),
    .count_o     (buf_count),
    .count_d_o   (buf_count_d)
  );

  assign pop  = m_valid && m_ready;
  assign push = fifo_valid && in_flight_q;

  // A word leaving the buffer this cycle frees its slot for the next strobe,
  // which is what sustains one word per cycle when downstream is ready.
  assign credit = {2'b00, in_flight_q} + {1'b0, buf_count} - {2'b00, pop};

  assign fifo_rd_en = (state_q == ST_READ) && !fifo_empty &&
                      (issue_left_q != '0) && (credit < 3'd2);
  assign in_flight_d = fifo_rd_en;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_left_q <= '0;
      recv_left_q  <= '0;
      words_read_q <= '0;
      in_flight_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= in_flight_d;
      if ((fifo_valid && !in_flight_q) || fifo_underflow) err_q <= 1'b1;
      if (pop) words_read_q <= words_read_q + cnt_width'(1);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              issue_left_q <= burst_len;
              recv_left_q  <= burst_len;
              words_read_q <= '0;
              busy_q       <= 1'b1;
              state_q      <= ST_READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (fifo_rd_en) issue_left_q <= issue_left_q - cnt_width'(1);
          if (push) recv_left_q <= recv_left_q - cnt_width'(1);
          if ((issue_left_q == '0) && (recv_left_q == '0)) begin
            // Buffer emptying on this edge finishes without a DRAIN cycle.
            if (buf_count_d == 2'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (buf_count_d == 2'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_read = words_read_q;
  assign err        = err_q;

endmodule
